// File: rtl/if_tag_pkg.sv
// Shared definitions for the IF buffer producer: row-framing tags, FSM encoding
// and the IF word width helper.
package if_tag_pkg;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_END    = 2'b01;
  localparam logic [1:0] TAG_START  = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // An IF word is the raw sample with the 2-bit framing tag on top.
  function automatic int unsigned if_word_w(input int unsigned sample_w);
    return sample_w + 2;
  endfunction

endpackage

// File: rtl/if_tag_gen.sv
// Combinational row-framing tag generator; maps a column position within a row
// to the tag the IF scratchpad expects.
module if_tag_gen
  import if_tag_pkg::*;
#(
  parameter int ROW_LEN_W = 8
) (
  input  logic [ROW_LEN_W-1:0] col_cnt,
  input  logic [ROW_LEN_W-1:0] row_len,
  output logic [1:0]           tag
);

  always_comb begin
    tag = TAG_MID;
    // A one-word row is both start and end, so it outranks the other cases.
    if (row_len == ROW_LEN_W'(1)) begin
      tag = TAG_SINGLE;
    end else if (col_cnt == '0) begin
      tag = TAG_START;
    end else if (col_cnt == row_len - ROW_LEN_W'(1)) begin
      tag = TAG_END;
    end
  end

endmodule

// File: rtl/if_stream_tagger.sv
// Transmit-side IF buffer producer: tags a valid/ready sample stream with row
// framing, honours IF_full backpressure and reports frame completion.
module if_stream_tagger
  import if_tag_pkg::*;
#(
  parameter int IF_SCRATCH_WIDTH = 16,
  parameter int FILT_ADDR_LEN    = 4,
  parameter int ROW_LEN_W        = 8,
  parameter int ROW_CNT_W        = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [ROW_LEN_W-1:0]                    row_len,
  input  logic [ROW_CNT_W-1:0]                    num_rows,
  input  logic [FILT_ADDR_LEN-1:0]                filt_len,
  input  logic                                    s_valid,
  input  logic [IF_SCRATCH_WIDTH-1:0]             s_data,
  output logic                                    s_ready,
  input  logic                                    IF_full,
  output logic                                    IF_wen,
  output logic [if_word_w(IF_SCRATCH_WIDTH)-1:0]  IF_din,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    cfg_err,
  output logic [1:0]                              dbg_state,
  output logic [ROW_CNT_W-1:0]                    dbg_row_cnt
);

  // Handshake: a sample moves in any cycle where s_valid && s_ready; the producer
  // must hold s_data stable while s_valid is high and s_ready is low.
  logic [1:0]           state_q, state_d;
  logic [ROW_LEN_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_LEN_W-1:0] row_len_q, row_len_d;
  logic [ROW_CNT_W-1:0] num_rows_q, num_rows_d;
  logic                 busy_q, done_q, cfg_err_q, cfg_err_d;

  logic       xfer;
  logic       last_col;
  logic       last_row;
  logic       cfg_bad;
  logic [1:0] tag;

  if_tag_gen #(.ROW_LEN_W(ROW_LEN_W)) u_tag_gen (
    .col_cnt (col_cnt_q),
    .row_len (row_len_q),
    .tag     (tag)
  );

  // abort also drops s_ready so the upstream never believes an aborted word landed.
  assign s_ready  = (state_q == STREAM) && !IF_full && !abort;
  assign xfer     = s_valid && s_ready;
  assign IF_wen   = xfer;
  assign IF_din   = {tag, s_data};
  assign last_col = (col_cnt_q == row_len_q - ROW_LEN_W'(1));
  assign last_row = (row_cnt_q == num_rows_q - ROW_CNT_W'(1));
  assign cfg_bad  = (row_len == '0) || (num_rows == '0) ||
                    (32'(row_len) < 32'(filt_len));

  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    row_cnt_d  = row_cnt_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    cfg_err_d  = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              row_len_d  = row_len;
              num_rows_d = num_rows;
              col_cnt_d  = '0;
              row_cnt_d  = '0;
              state_d    = STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_col) begin
              col_cnt_d = '0;
              row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
              if (last_row) begin
                state_d = DONE;
              end
            end else begin
              col_cnt_d = col_cnt_q + ROW_LEN_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      busy_q     <= (state_d == STREAM);
      done_q     <= (state_d == DONE);
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign dbg_state   = state_q;
  assign dbg_row_cnt = row_cnt_q;

endmodule

// File: tb/tb_if_stream_tagger.sv
// Directed bench for if_stream_tagger: framing tags, backpressure, multi-row,
// single-word rows, illegal configuration, abort and asynchronous reset.
module tb_if_stream_tagger;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  row_len;
  logic [7:0]  num_rows;
  logic [3:0]  filt_len;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        IF_full;
  logic        IF_wen;
  logic [17:0] IF_din;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_row_cnt;

  int total = 0;
  int bad   = 0;
  int wen_cnt  = 0;
  int done_cnt = 0;
  int wen_base;
  int done_base;

  if_stream_tagger dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .row_len     (row_len),
    .num_rows    (num_rows),
    .filt_len    (filt_len),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .IF_full     (IF_full),
    .IF_wen      (IF_wen),
    .IF_din      (IF_din),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .dbg_state   (dbg_state),
    .dbg_row_cnt (dbg_row_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (IF_wen === 1'b1) wen_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] rl, input logic [7:0] nr, input logic [3:0] fl);
    row_len  = rl;
    num_rows = nr;
    filt_len = fl;
    start    = 1'b1;
    s_valid  = 1'b0;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [15:0] d, input logic [17:0] exp_din);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    chk({tag, "_wen"}, 32'(IF_wen), 32'd1);
    chk({tag, "_din"}, 32'(IF_din), 32'(exp_din));
    next_cycle();
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; row_len = '0; num_rows = '0;
    filt_len = '0; s_valid = 1'b0; s_data = '0; IF_full = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_wen", 32'(IF_wen), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // single row
    wen_base = wen_cnt;
    do_start(8'd5, 8'd1, 4'd3);
    chk("sr_busy", 32'(busy), 32'd1);
    chk("sr_ready", 32'(s_ready), 32'd1);
    send_word("sr_w0", 16'd161, 18'h200A1);
    send_word("sr_w1", 16'd190, 18'h000BE);
    send_word("sr_w2", 16'hFF5F, 18'h0FF5F);
    send_word("sr_w3", 16'hFFAF, 18'h0FFAF);
    send_word("sr_w4", 16'd50, 18'h10032);
    chk("sr_done", 32'(done), 32'd1);
    chk("sr_busy_fall", 32'(busy), 32'd0);
    chk("sr_ready_done", 32'(s_ready), 32'd0);
    next_cycle();
    chk("sr_done_fall", 32'(done), 32'd0);
    chk("sr_idle", 32'(dbg_state), 32'd0);
    chk("sr_wen_count", 32'(wen_cnt - wen_base), 32'd5);

    // backpressure after the 2nd word
    wen_base = wen_cnt;
    do_start(8'd5, 8'd1, 4'd3);
    send_word("bp_w0", 16'd161, 18'h200A1);
    send_word("bp_w1", 16'd190, 18'h000BE);
    IF_full = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hFF5F;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", 32'(s_ready), 32'd0);
      chk("bp_wen_low", 32'(IF_wen), 32'd0);
      next_cycle();
    end
    IF_full = 1'b0;
    send_word("bp_w2", 16'hFF5F, 18'h0FF5F);
    send_word("bp_w3", 16'hFFAF, 18'h0FFAF);
    send_word("bp_w4", 16'd50, 18'h10032);
    chk("bp_done", 32'(done), 32'd1);
    next_cycle();
    chk("bp_wen_count", 32'(wen_cnt - wen_base), 32'd5);

    // multi-row with an ignored start in the middle
    done_base = done_cnt;
    do_start(8'd3, 8'd2, 4'd2);
    send_word("mr_w0", 16'h0001, 18'h20001);
    send_word("mr_w1", 16'h0002, 18'h00002);
    start = 1'b1; row_len = 8'd0;
    send_word("mr_w2", 16'h0003, 18'h10003);
    start = 1'b0;
    chk("mr_no_cfg_err", 32'(cfg_err), 32'd0);
    chk("mr_row_cnt1", 32'(dbg_row_cnt), 32'd1);
    send_word("mr_w3", 16'h0004, 18'h20004);
    send_word("mr_w4", 16'h0005, 18'h00005);
    send_word("mr_w5", 16'h0006, 18'h10006);
    chk("mr_row_cnt2", 32'(dbg_row_cnt), 32'd2);
    chk("mr_done", 32'(done), 32'd1);
    next_cycle();
    next_cycle();
    chk("mr_done_count", 32'(done_cnt - done_base), 32'd1);

    // single-word rows
    do_start(8'd1, 8'd3, 4'd1);
    send_word("sw_w0", 16'h1234, 18'h31234);
    send_word("sw_w1", 16'h8000, 18'h38000);
    chk("sw_busy_mid", 32'(busy), 32'd1);
    send_word("sw_w2", 16'h7FFF, 18'h37FFF);
    chk("sw_done", 32'(done), 32'd1);
    next_cycle();

    // illegal configuration, then a legal one
    wen_base = wen_cnt;
    do_start(8'd2, 8'd1, 4'd3);
    s_valid = 1'b1;
    #1;
    chk("ill_cfg_err", 32'(cfg_err), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_state", 32'(dbg_state), 32'd0);
    chk("ill_ready", 32'(s_ready), 32'd0);
    chk("ill_wen", 32'(IF_wen), 32'd0);
    next_cycle();
    s_valid = 1'b0;
    chk("ill_cfg_err_fall", 32'(cfg_err), 32'd0);
    chk("ill_wen_count", 32'(wen_cnt - wen_base), 32'd0);
    do_start(8'd0, 8'd4, 4'd0);
    chk("ill_zero_len", 32'(cfg_err), 32'd1);
    do_start(8'd2, 8'd1, 4'd2);
    chk("leg_cfg_err", 32'(cfg_err), 32'd0);
    send_word("leg_w0", 16'hABCD, 18'h2ABCD);
    send_word("leg_w1", 16'h0042, 18'h10042);
    chk("leg_done", 32'(done), 32'd1);
    next_cycle();

    // abort on the 3rd word
    done_base = done_cnt;
    do_start(8'd5, 8'd1, 4'd3);
    send_word("ab_w0", 16'd161, 18'h200A1);
    send_word("ab_w1", 16'd190, 18'h000BE);
    s_valid = 1'b1; s_data = 16'hFF5F; abort = 1'b1;
    #1;
    chk("ab_wen", 32'(IF_wen), 32'd0);
    next_cycle();
    abort = 1'b0; s_valid = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_state", 32'(dbg_state), 32'd0);
    next_cycle();
    chk("ab_done_count", 32'(done_cnt - done_base), 32'd0);
    do_start(8'd2, 8'd1, 4'd1);
    send_word("ab_fresh_w0", 16'h0055, 18'h20055);
    send_word("ab_fresh_w1", 16'h0066, 18'h10066);
    next_cycle();

    // asynchronous reset mid-row
    do_start(8'd5, 8'd1, 4'd3);
    send_word("rr_w0", 16'd161, 18'h200A1);
    send_word("rr_w1", 16'd190, 18'h000BE);
    s_valid = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    chk("rr_cfg_err", 32'(cfg_err), 32'd0);
    chk("rr_ready", 32'(s_ready), 32'd0);
    chk("rr_wen", 32'(IF_wen), 32'd0);
    s_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    do_start(8'd2, 8'd1, 4'd2);
    send_word("rr_fresh_w0", 16'h0777, 18'h20777);
    send_word("rr_fresh_w1", 16'h0888, 18'h10888);
    chk("rr_fresh_done", 32'(done), 32'd1);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stream_tagger.md
Name: if_stream_tagger

Overview:
- Transmit-side producer for the IF (input feature map) buffer of the conv accelerator.
- Accepts raw 16-bit ifmap samples over a valid/ready stream and writes them into the IF buffer. Each word carries the 2-bit row-framing tag that the IF scratchpad reads: start-of-row, middle, end-of-row, or single-word row.
- Counts columns and rows, honours IF_full backpressure, rejects configurations the PE cannot convolve, and signals completion.
- Sits between the host/DMA side and design_top's IF_wen/IF_din/IF_full port.

Parameters:
- IF_SCRATCH_WIDTH, 16, ifmap sample width; IF_din is IF_SCRATCH_WIDTH+2 bits.
- FILT_ADDR_LEN, 4, width of the filt_len configuration field.
- ROW_LEN_W, 8, width of the row-length configuration and column counter.
- ROW_CNT_W, 8, width of the row-count configuration and row counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches the configuration. Honoured only in IDLE.
- abort  in  1  one-cycle pulse; returns the block to IDLE without writing further words.
- row_len  in  ROW_LEN_W  samples per row; latched on start.
- num_rows  in  ROW_CNT_W  rows per frame; latched on start.
- filt_len  in  FILT_ADDR_LEN  filter length; used only for the start-time legality check.
- s_valid  in  1  input sample valid.
- s_data  in  IF_SCRATCH_WIDTH  input sample, two's complement, passed through unmodified.
- s_ready  out  1  block can accept a sample this cycle.
- IF_full  in  1  IF buffer full flag.
- IF_wen  out  1  IF buffer write enable.
- IF_din  out  IF_SCRATCH_WIDTH+2  {tag[1:0], sample}.
- busy  out  1  high in STREAM state.
- done  out  1  one-cycle pulse after the last word of the frame is written.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; col_cnt=0, row_cnt=0; latched row_len and num_rows = 0.
  - Registered outputs busy, done and cfg_err = 0.
  - s_ready and IF_wen evaluate to 0 because state is IDLE.
- States:
  - IDLE: on start, check the configuration.
    - Illegal (row_len==0, num_rows==0, or row_len<filt_len): pulse cfg_err next cycle and stay in IDLE.
    - Legal: latch row_len and num_rows, clear both counters, go to STREAM.
  - STREAM: s_ready = !IF_full.
    - Transfer when s_valid && s_ready. IF_wen = transfer and IF_din = {tag, s_data}, both combinational, so there is zero latency and no extra FIFO slot is needed.
    - Tag is computed from col_cnt and the latched row_len:
      - row_len==1 → 2'b11.
      - col_cnt==0 → 2'b10.
      - col_cnt==row_len-1 → 2'b01.
      - otherwise → 2'b00.
    - On transfer: if col_cnt==row_len-1, then col_cnt←0 and row_cnt←row_cnt+1; otherwise col_cnt←col_cnt+1.
    - On the transfer of the last word of the last row, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. s_ready=0.
- Backpressure:
  - While IF_full=1: s_ready=0, IF_wen=0, counters hold.
  - The tag sequence resumes unchanged after IF_full deasserts.
  - IF_full rising in the same cycle that s_valid rises means no transfer.
- start while in STREAM or DONE: ignored (no cfg_err). A new configuration needs IDLE.
- abort:
  - Highest priority over a transfer in the same cycle: IF_wen is forced to 0 that cycle.
  - Next state IDLE, counters cleared, no done pulse.
  - A truncated row is left without an end tag; recovery is the caller's responsibility (reset design_top).
- abort together with start in IDLE: abort wins, start is ignored.
- busy = (state==STREAM), registered along with state.
- Counter widths: col_cnt is ROW_LEN_W bits, row_cnt is ROW_CNT_W bits. Maximum values never wrap because termination is compared against the latched limits.
- Rejected start: no state change and no writes.

Decomposition:
- Package if_tag_pkg holds:
  - tag constants TAG_MID=2'b00, TAG_END=2'b01, TAG_START=2'b10, TAG_SINGLE=2'b11;
  - state encoding IDLE/STREAM/DONE;
  - the IF word width function.
- One natural sub-module: if_tag_gen. It is purely combinational, maps (col_cnt, row_len) to a tag, and can be shared with the IF scratchpad checker.

Test Plan:
- Single row: row_len=5, num_rows=1, filt_len=3, samples 161,190,-161,-81,50, IF_full=0.
  - IF_din = 18'h200A1, 18'h000BE, 18'h0FF5F, 18'h0FFAF, 18'h10032 on 5 consecutive cycles.
  - done pulses on the cycle after the 5th write; busy falls with it.
- Backpressure: same frame, IF_full=1 for 3 cycles after the 2nd word.
  - s_ready=0 and no IF_wen for those 3 cycles.
  - The 3rd word still carries tag 00 and the 5th carries 01; total IF_wen count = 5.
- Multi-row: row_len=3, num_rows=2.
  - Tags 10,00,01,10,00,01; row_cnt reaches 2; exactly one done pulse.
- row_len=1, num_rows=3, filt_len=1: three words, each with tag 11, then done.
- Illegal configuration: row_len=2, filt_len=3.
  - cfg_err pulses once; state stays IDLE; s_ready=0; no IF_wen.
  - A legal start afterwards streams normally.
- Mid-stream aborts:
  - abort asserted with s_valid=1 on the 3rd word: no write that cycle, busy falls next cycle, no done.
  - rst pulled low mid-row: all outputs 0 immediately.
  - After either, a fresh start begins again with tag 10.
